// File: rtl/nios0_ip_mem_fill_check.sv
// nios0_ip_mem_fill_check
//   Memory fill / verify engine for an attached on-chip RAM. Software
//   programs START, COUNT and PATTERN over a small CSR slave, then writes
//   CTRL with GO. In fill mode the block writes one word per cycle. In
//   verify mode it reads one word per cycle and compares each return with
//   the expected data, recording ERROR and the first failing address.
//   Expected data is PATTERN, or PATTERN + word index when INCR is set.
//
// Ports
//   clk, reset       : single clock, asynchronous active-high reset
//   csr_*            : Avalon-MM slave, zero wait states, registered readdata
//                      0 START, 1 COUNT, 2 PATTERN, 3 CTRL(write)/STATUS(read)
//   mem_*            : Avalon-MM master to the RAM; readdata is valid one
//                      cycle after its address is presented
//   irq              : level interrupt, registered IRQ_EN & DONE
module nios0_ip_mem_fill_check #(
  parameter int unsigned MEM_DEPTH = 25600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  csr_address,
  input  logic        csr_chipselect,
  input  logic        csr_write,
  input  logic        csr_read,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [14:0] mem_address,
  output logic        mem_chipselect,
  output logic        mem_write,
  output logic        mem_clken,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  output logic        irq
);

  localparam logic [14:0] LAST_ADDR = 15'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_VREAD,
    S_VDRAIN,
    S_FINISH
  } state_t;

  state_t state, state_next;

  logic [14:0] start_reg;
  logic [15:0] count_reg;
  logic [31:0] pattern_reg;
  logic        incr_reg;
  logic        irq_en;
  logic        done;
  logic        error;
  logic [14:0] fail_addr;

  logic [14:0] addr_cnt;
  logic [15:0] remaining;
  logic [31:0] cur_data;

  // Verify pipeline: expected word and address of the read issued last cycle
  logic        cmp_valid;
  logic [31:0] exp_d;
  logic [14:0] addr_d;

  logic busy;
  logic wr_en;
  logic rd_en;
  logic ctrl_wr;
  logic go;
  logic access;
  logic last_word;

  assign busy      = (state != S_IDLE);
  assign wr_en     = csr_chipselect & csr_write;
  assign rd_en     = csr_chipselect & csr_read;
  assign ctrl_wr   = wr_en & (csr_address == 2'd3);
  assign go        = ctrl_wr & csr_writedata[0] & ~busy;
  assign access    = (state == S_FILL) | (state == S_VREAD);
  assign last_word = (remaining == 16'd1);

  assign mem_clken      = 1'b1;
  assign mem_chipselect = access;
  assign mem_write      = (state == S_FILL);
  assign mem_byteenable = access ? 4'hF : '0;
  assign mem_address    = addr_cnt;
  assign mem_writedata  = cur_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (go) begin
          if (count_reg == '0)         state_next = S_FINISH;
          else if (csr_writedata[1])   state_next = S_VREAD;
          else                         state_next = S_FILL;
        end
      end
      S_FILL:   if (last_word) state_next = S_FINISH;
      S_VREAD:  if (last_word) state_next = S_VDRAIN;
      S_VDRAIN: state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_reg    <= '0;
      count_reg    <= '0;
      pattern_reg  <= '0;
      incr_reg     <= 1'b0;
      irq_en       <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      fail_addr    <= '0;
      addr_cnt     <= '0;
      remaining    <= '0;
      cur_data     <= '0;
      cmp_valid    <= 1'b0;
      exp_d        <= '0;
      addr_d       <= '0;
      irq          <= 1'b0;
      csr_readdata <= '0;
    end else begin
      if (wr_en && !busy) begin
        case (csr_address)
          2'd0: start_reg   <= csr_writedata[14:0];
          2'd1: count_reg   <= csr_writedata[15:0];
          2'd2: pattern_reg <= csr_writedata;
          2'd3: incr_reg    <= csr_writedata[3];
          default: ;
        endcase
      end

      if (ctrl_wr) begin
        irq_en <= csr_writedata[2];
        if (csr_writedata[4]) begin
          done  <= 1'b0;
          error <= 1'b0;
        end
      end

      if (go && count_reg != '0) begin
        done      <= 1'b0;
        error     <= 1'b0;
        fail_addr <= '0;
        addr_cnt  <= start_reg;
        remaining <= count_reg;
        cur_data  <= pattern_reg;
      end

      if (access) begin
        addr_cnt  <= (addr_cnt == LAST_ADDR) ? '0 : addr_cnt + 15'd1;
        remaining <= remaining - 16'd1;
        if (incr_reg) cur_data <= cur_data + 32'd1;
      end

      cmp_valid <= (state == S_VREAD);
      exp_d     <= cur_data;
      addr_d    <= addr_cnt;

      // Mismatch and FINISH are ordered after CLR so they win a same-cycle clear
      if (cmp_valid && mem_readdata != exp_d) begin
        error <= 1'b1;
        if (!error) fail_addr <= addr_d;
      end

      if (state == S_FINISH) done <= 1'b1;

      irq <= irq_en & done;

      if (rd_en) begin
        case (csr_address)
          2'd0:    csr_readdata <= {17'd0, start_reg};
          2'd1:    csr_readdata <= {16'd0, count_reg};
          2'd2:    csr_readdata <= pattern_reg;
          default: csr_readdata <= {1'b0, fail_addr, 12'd0, irq_en, error, done, busy};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nios0_ip_mem_fill_check.sv
module tb_nios0_ip_mem_fill_check;

  localparam int unsigned D = 25600;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  csr_address;
  logic        csr_chipselect;
  logic        csr_write;
  logic        csr_read;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic [14:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic        mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        irq;

  nios0_ip_mem_fill_check #(.MEM_DEPTH(D)) dut (
    .clk           (clk),
    .reset         (reset),
    .csr_address   (csr_address),
    .csr_chipselect(csr_chipselect),
    .csr_write     (csr_write),
    .csr_read      (csr_read),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .mem_address   (mem_address),
    .mem_chipselect(mem_chipselect),
    .mem_write     (mem_write),
    .mem_clken     (mem_clken),
    .mem_byteenable(mem_byteenable),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Bus-side RAM plus a corruption mask applied on the read path
  logic [31:0] mem  [D];
  logic [31:0] flip [D];
  logic [14:0] wq_a[$];
  logic [31:0] wq_d[$];
  logic [14:0] rq_a[$];
  logic [3:0]  be_seen;

  always @(posedge clk) begin
    if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
    mem_readdata <= mem[mem_address] ^ flip[mem_address];
    if (!reset && mem_chipselect) begin
      be_seen = mem_byteenable;
      if (mem_write) begin
        wq_a.push_back(mem_address);
        wq_d.push_back(mem_writedata);
      end else begin
        rq_a.push_back(mem_address);
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [int];
  bit          m_ien;
  bit          m_err;
  logic [14:0] m_fail;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_writedata = d; csr_chipselect = 1'b1; csr_write = 1'b1;
    @(negedge clk);
    csr_chipselect = 1'b0; csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_chipselect = 1'b1; csr_read = 1'b1;
    @(negedge clk);
    csr_chipselect = 1'b0; csr_read = 1'b0;
    d = csr_readdata;
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] pat, input bit inc, input int i);
    return inc ? pat + 32'(i) : pat;
  endfunction

  task automatic do_op(input logic [14:0] st, input logic [15:0] cnt, input logic [31:0] pat,
                       input bit mode, input bit inc, input bit ien);
    int busy_n;
    int a;
    logic [31:0] sts;
    logic [31:0] e;
    csr_wr(2'd0, {17'd0, st});
    csr_wr(2'd1, {16'd0, cnt});
    csr_wr(2'd2, pat);
    m_ien = ien;
    if (cnt != 0) begin
      m_err  = 1'b0;
      m_fail = '0;
      for (int i = 0; i < int'(cnt); i++) begin
        a = (int'(st) + i) % D;
        e = exp_word(pat, inc, i);
        if (mode) begin
          if (!ref_mem.exists(a) || (ref_mem[a] ^ flip[a]) != e) begin
            if (!m_err) m_fail = 15'(a);
            m_err = 1'b1;
          end
        end else begin
          ref_mem[a] = e;
        end
      end
    end
    wq_a.delete(); wq_d.delete(); rq_a.delete();
    csr_wr(2'd3, {28'd0, inc, ien, mode, 1'b1});
    csr_address = 2'd3; csr_chipselect = 1'b1; csr_read = 1'b1;
    busy_n = 0;
    @(negedge clk);
    while (csr_readdata[0] && busy_n < 400) begin
      busy_n++;
      @(negedge clk);
    end
    sts = csr_readdata;
    csr_chipselect = 1'b0; csr_read = 1'b0;
    check("busy_cycles", 32'(busy_n), (cnt == 0) ? 32'd1 : (mode ? 32'(cnt) + 32'd2 : 32'(cnt) + 32'd1));
    check("n_writes", 32'(wq_a.size()), mode ? 32'd0 : 32'(cnt));
    check("n_reads", 32'(rq_a.size()), mode ? 32'(cnt) : 32'd0);
    for (int i = 0; i < int'(cnt); i++) begin
      a = (int'(st) + i) % D;
      if (mode) begin
        if (i < rq_a.size()) check("rd_addr", 32'(rq_a[i]), 32'(a));
      end else if (i < wq_a.size()) begin
        check("wr_addr", 32'(wq_a[i]), 32'(a));
        check("wr_data", wq_d[i], exp_word(pat, inc, i));
      end
    end
    if (cnt != 0) check("byteenable", 32'(be_seen), 32'hF);
    check("status", sts, {1'b0, m_fail, 12'd0, m_ien, m_err, 1'b1, 1'b0});
    @(negedge clk);
    check("irq", 32'(irq), 32'(m_ien));
  endtask

  initial begin
    logic [31:0] rd;
    int st;
    int cnt;
    int a;
    logic [31:0] pat;
    bit inc;
    int nq;
    int guard;

    for (int i = 0; i < int'(D); i++) flip[i] = '0;
    csr_address = '0; csr_chipselect = 1'b0; csr_write = 1'b0; csr_read = 1'b0;
    csr_writedata = '0;
    m_ien = 1'b0; m_err = 1'b0; m_fail = '0;
    reset = 1'b1;
    #1;
    check("rst_readdata", csr_readdata, 32'd0);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_we", 32'(mem_write), 32'd0);
    check("rst_be", 32'(mem_byteenable), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_wdata", mem_writedata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("clken", 32'(mem_clken), 32'd1);
    for (int r = 0; r < 4; r++) begin
      csr_rd(2'(r), rd);
      check("rst_csr", rd, 32'd0);
    end

    // Directed fill and verify of four incrementing words
    do_op(15'h10, 16'd4, 32'hA5A5_0000, 1'b0, 1'b1, 1'b0);
    do_op(15'h10, 16'd4, 32'hA5A5_0000, 1'b1, 1'b1, 1'b0);
    flip[16'h12] = 32'h0000_0100;
    flip[16'h13] = 32'h8000_0000;
    do_op(15'h10, 16'd4, 32'hA5A5_0000, 1'b1, 1'b1, 1'b0);
    flip[16'h12] = '0;
    flip[16'h13] = '0;

    // Address wrap at the top of memory
    do_op(15'(D - 2), 16'd3, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    do_op(15'(D - 2), 16'd3, 32'h1234_5678, 1'b1, 1'b0, 1'b0);

    // COUNT=0 with interrupt enabled, then clear
    do_op(15'h55, 16'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("irq_hold", 32'(irq), 32'd1);
    csr_wr(2'd3, 32'h14);
    m_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'd0);
    csr_rd(2'd3, rd);
    check("status_clr", rd, {1'b0, m_fail, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0});

    // Writes while busy: only IRQ_EN takes effect
    csr_wr(2'd0, 32'h200);
    csr_wr(2'd1, 32'd8);
    csr_wr(2'd2, 32'h11);
    wq_a.delete(); wq_d.delete(); rq_a.delete();
    csr_wr(2'd3, 32'h1);
    csr_wr(2'd0, 32'h7FFF);
    csr_wr(2'd1, 32'd0);
    csr_wr(2'd3, 32'h7);
    repeat (20) @(negedge clk);
    csr_rd(2'd0, rd);
    check("busy_start", rd, 32'h200);
    csr_rd(2'd1, rd);
    check("busy_count", rd, 32'd8);
    check("busy_nwr", 32'(wq_a.size()), 32'd8);
    check("busy_nrd", 32'(rq_a.size()), 32'd0);
    csr_rd(2'd3, rd);
    check("busy_irqen", rd, {17'd0, 11'd0, 4'b1010});
    for (int i = 0; i < 8; i++) ref_mem[16'h200 + i] = 32'h11;

    // Randomized fill then verify with random corruption
    for (int it = 0; it < 12; it++) begin
      st  = ($urandom_range(0, 3) == 0) ? int'(D) - int'($urandom_range(1, 10)) : int'($urandom_range(0, D - 1));
      cnt = int'($urandom_range(1, 24));
      pat = $urandom;
      inc = 1'($urandom_range(0, 1));
      do_op(15'(st), 16'(cnt), pat, 1'b0, inc, 1'($urandom_range(0, 1)));
      nq = int'($urandom_range(0, 2));
      for (int k = 0; k < nq; k++) begin
        a = (st + int'($urandom_range(0, cnt - 1))) % D;
        flip[a] = $urandom | 32'h1;
      end
      do_op(15'(st), 16'(cnt), pat, 1'b1, inc, 1'($urandom_range(0, 1)));
      for (int i = 0; i < cnt; i++) flip[(st + i) % D] = '0;
    end

    // Reset in the middle of a long fill
    csr_wr(2'd0, 32'd100);
    csr_wr(2'd1, 32'd100);
    csr_wr(2'd2, 32'hCAFE_0000);
    wq_a.delete(); wq_d.delete(); rq_a.delete();
    csr_wr(2'd3, 32'h9);
    guard = 0;
    while (wq_a.size() < 50 && guard < 300) begin
      guard++;
      @(negedge clk);
    end
    check("mid_reached", 32'(wq_a.size() >= 50), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_we", 32'(mem_write), 32'd0);
    check("abort_cs", 32'(mem_chipselect), 32'd0);
    nq = wq_a.size();
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_nwr", 32'(wq_a.size()), 32'(nq));
    check("abort_irq", 32'(irq), 32'd0);
    for (int r = 0; r < 4; r++) begin
      csr_rd(2'(r), rd);
      check("abort_csr", rd, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nios0_ip_mem_fill_check.md
NIOS0_IP_MEM_FILL_CHECK -- requirements
Module: nios0_ip_mem_fill_check

Interface
REQ-001 The block SHALL have one parameter: MEM_DEPTH, default 25600, number of 32-bit words in the attached on-chip memory.
REQ-002 The block SHALL have port clk, input, 1, single clock for all logic.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port csr_address, input, 2, CSR word select.
REQ-005 The block SHALL have ports csr_chipselect, csr_write and csr_read, input, 1 each, CSR Avalon-MM slave strobes with zero wait states.
REQ-006 The block SHALL have port csr_writedata, input, 32, CSR write data.
REQ-007 The block SHALL have port csr_readdata, output, 32, registered CSR read data.
REQ-008 The block SHALL have port mem_address, output, 15, memory word address.
REQ-009 The block SHALL have ports mem_chipselect, mem_write and mem_clken, output, 1 each, memory strobes.
REQ-010 The block SHALL have port mem_byteenable, output, 4, memory byte enables.
REQ-011 The block SHALL have port mem_writedata, output, 32, memory write data.
REQ-012 The block SHALL have port mem_readdata, input, 32, memory read data, valid the cycle after its address is presented.
REQ-013 The block SHALL have port irq, output, 1, level interrupt.

Function
REQ-014 CSR map SHALL be: 0 START (bits 14:0, R/W); 1 COUNT (bits 15:0 in words, R/W); 2 PATTERN (32 bits, R/W); 3 CTRL/STATUS.
REQ-015 CTRL writes SHALL decode as: bit0 GO; bit1 MODE (0 fill, 1 verify); bit2 IRQ_EN; bit3 INCR (data = PATTERN + word index, 32-bit wrap); bit4 CLR, which is write-1-to-clear for DONE and ERROR.
REQ-016 STATUS reads SHALL return: bit0 BUSY; bit1 DONE; bit2 ERROR; bit3 IRQ_EN; bits 30:16 first failing address; all other bits 0.
REQ-017 csr_readdata SHALL update on the clock edge where csr_chipselect & csr_read are high, so data is valid the following cycle.
REQ-018 While BUSY, writes to START, COUNT, PATTERN and GO SHALL be ignored, but IRQ_EN and CLR writes SHALL take effect.
REQ-019 The FSM SHALL have the states IDLE, FILL, VREAD, VDRAIN and FINISH.
REQ-020 In IDLE, GO=1 with COUNT=0 SHALL go to FINISH with no memory access.
REQ-021 In IDLE, GO=1 with COUNT>0 SHALL clear DONE, ERROR and the failing address, load the address counter from START and the remaining counter from COUNT, then enter FILL (MODE=0) or VREAD (MODE=1).
REQ-022 In FILL, the block SHALL issue one write per cycle (mem_chipselect=1, mem_write=1, mem_byteenable=4'hF), and on the last word SHALL go to FINISH.
REQ-023 In VREAD, the block SHALL issue one read per cycle (mem_chipselect=1, mem_write=0).
REQ-024 The block SHALL compare mem_readdata in the cycle after each read against the expected data delayed by one cycle.
REQ-025 After the last read is issued, the block SHALL enter VDRAIN for one compare-only cycle, then go to FINISH.
REQ-026 On a verify mismatch, ERROR SHALL be set, and the failing address SHALL be captured on the first mismatch only; verification SHALL continue to the end.
REQ-027 The address SHALL increment by 1 per access and wrap from MEM_DEPTH-1 to 0.
REQ-028 FINISH SHALL set DONE and return to IDLE on the next cycle; BUSY SHALL be 1 in FILL, VREAD, VDRAIN and FINISH.
REQ-029 irq SHALL equal IRQ_EN & DONE, registered.
REQ-030 mem_clken SHALL be constant 1.
REQ-031 Outside FILL and VREAD, mem_chipselect and mem_write SHALL be 0.
REQ-032 If CLR and the FSM setting DONE occur in the same cycle, setting DONE SHALL win.

Reset
REQ-033 On reset assertion, asynchronously: FSM=IDLE; all CSRs, counters, DONE, ERROR and the failing address =0; csr_readdata=0; mem_address=0; mem_writedata=0; mem_chipselect=0; mem_write=0; mem_byteenable=0; irq=0.
REQ-034 Reset mid-operation SHALL abort the operation immediately with no further memory access; no state SHALL survive.

Verification
REQ-035 Fill: START=0x10, COUNT=4, PATTERN=0xA5A5_0000, INCR=1, GO -> writes of 0xA5A50000..0xA5A50003 to addresses 0x10..0x13 on 4 consecutive cycles, then DONE=1.
REQ-036 Verify pass: after the fill, MODE=1, GO with memory model matching -> 4 reads, DONE=1, ERROR=0, total BUSY=6 cycles.
REQ-037 Verify fail: corrupt address 0x12 and 0x13 -> ERROR=1, STATUS[30:16]=0x12.
REQ-038 Wrap: START=25598, COUNT=3 -> addresses 25598, 25599, 0.
REQ-039 COUNT=0 GO -> no mem_chipselect pulse, DONE=1 after 2 cycles; with IRQ_EN=1, irq=1 until CLR is written.
REQ-040 Reset asserted during a FILL of COUNT=100 at word 50 -> mem_write=0 immediately, all CSRs read 0 after release.
